pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_pkg.sv | 12 +
 rtl/pipe_hazard_ctrl_hazard_detect.sv | 23 ++
 rtl/pipe_hazard_ctrl.sv | 124 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions: multiply/divide tracker states and default latency.
package pipe_hazard_ctrl_pkg;

    typedef enum logic {
        ST_RUN,
        ST_MDU_BUSY
    } mdu_state_t;

    localparam int unsigned MULDIV_CYCLES_DEFAULT = 32;
    localparam int unsigned MDU_CNT_WIDTH         = 8;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use and HI/LO dependency detection for the decode stage.
module hazard_detect #(
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic [REG_ADDR_WIDTH-1:0] i_ID_Rs,
    input  logic [REG_ADDR_WIDTH-1:0] i_ID_Rt,
    input  logic                      i_ID_Uses_Rt,
    input  logic                      i_ID_Reads_HiLo,
    input  logic                      i_EX_MemRead,
    input  logic [REG_ADDR_WIDTH-1:0] i_EX_Rd,
    input  logic                      i_MDU_Busy,
    output logic                      o_Load_Use,
    output logic                      o_HiLo_Hazard
);

    always_comb begin
        // $0 is hardwired, so a load targeting it never creates a dependency
        o_Load_Use    = i_EX_MemRead && (i_EX_Rd != '0) &&
                        ((i_EX_Rd == i_ID_Rs) || (i_ID_Uses_Rt && (i_EX_Rd == i_ID_Rt)));
        o_HiLo_Hazard = i_ID_Reads_HiLo && i_MDU_Busy;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stall/flush priority mux, multiply/divide busy tracker
// and a saturating stall-cycle counter.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned MULDIV_CYCLES  = MULDIV_CYCLES_DEFAULT,
    parameter int unsigned COUNT_WIDTH    = 32
) (
    input  logic                      i_Clk,
    input  logic                      i_Reset_n,
    input  logic [REG_ADDR_WIDTH-1:0] i_ID_Rs,
    input  logic [REG_ADDR_WIDTH-1:0] i_ID_Rt,
    input  logic                      i_ID_Uses_Rt,
    input  logic                      i_ID_Reads_HiLo,
    input  logic                      i_EX_MemRead,
    input  logic [REG_ADDR_WIDTH-1:0] i_EX_Rd,
    input  logic                      i_Branch_Taken,
    input  logic                      i_MulDiv_Start,
    input  logic                      i_Dmem_Wait,
    output logic                      o_PC_Stall,
    output logic                      o_IF_DEC_Stall,
    output logic                      o_IF_DEC_Flush,
    output logic                      o_DEC_EX_Stall,
    output logic                      o_DEC_EX_Flush,
    output logic                      o_EX_MEM_Stall,
    output logic                      o_MEM_WB_Stall,
    output logic                      o_MulDiv_Busy,
    output logic [COUNT_WIDTH-1:0]    o_Stall_Count
);

    localparam logic [MDU_CNT_WIDTH-1:0] MDU_LOAD = MDU_CNT_WIDTH'(MULDIV_CYCLES - 1);
    localparam logic [MDU_CNT_WIDTH-1:0] MDU_ONE  = MDU_CNT_WIDTH'(1);

    mdu_state_t               state_q, state_d;
    logic [MDU_CNT_WIDTH-1:0] mdu_cnt_q, mdu_cnt_d;
    logic                     load_use;
    logic                     hilo_hazard;

    hazard_detect #(
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_hazard_detect (
        .i_ID_Rs         (i_ID_Rs),
        .i_ID_Rt         (i_ID_Rt),
        .i_ID_Uses_Rt    (i_ID_Uses_Rt),
        .i_ID_Reads_HiLo (i_ID_Reads_HiLo),
        .i_EX_MemRead    (i_EX_MemRead),
        .i_EX_Rd         (i_EX_Rd),
        .i_MDU_Busy      (o_MulDiv_Busy),
        .o_Load_Use      (load_use),
        .o_HiLo_Hazard   (hilo_hazard)
    );

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q   <= ST_RUN;
            mdu_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            mdu_cnt_q <= mdu_cnt_d;
        end
    end

    // The busy countdown keeps running through memory-wait freezes
    always_comb begin
        state_d   = state_q;
        mdu_cnt_d = mdu_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (i_MulDiv_Start) begin
                    state_d   = ST_MDU_BUSY;
                    mdu_cnt_d = MDU_LOAD;
                end
            end
            ST_MDU_BUSY: begin
                if (mdu_cnt_q == MDU_ONE) begin
                    state_d   = ST_RUN;
                    mdu_cnt_d = '0;
                end else begin
                    mdu_cnt_d = mdu_cnt_q - MDU_ONE;
                end
            end
            default: begin
                state_d   = ST_RUN;
                mdu_cnt_d = '0;
            end
        endcase
    end

    assign o_MulDiv_Busy = (state_q == ST_MDU_BUSY);

    always_comb begin
        o_PC_Stall     = 1'b0;
        o_IF_DEC_Stall = 1'b0;
        o_IF_DEC_Flush = 1'b0;
        o_DEC_EX_Stall = 1'b0;
        o_DEC_EX_Flush = 1'b0;
        o_EX_MEM_Stall = 1'b0;
        o_MEM_WB_Stall = 1'b0;
        if (i_Dmem_Wait) begin
            o_PC_Stall     = 1'b1;
            o_IF_DEC_Stall = 1'b1;
            o_DEC_EX_Stall = 1'b1;
            o_EX_MEM_Stall = 1'b1;
            o_MEM_WB_Stall = 1'b1;
        end else if (load_use || hilo_hazard) begin
            // Hold fetch/decode and push a bubble; a same-cycle branch is dropped
            o_PC_Stall     = 1'b1;
            o_IF_DEC_Stall = 1'b1;
            o_DEC_EX_Flush = 1'b1;
        end else if (i_Branch_Taken) begin
            o_IF_DEC_Flush = 1'b1;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            o_Stall_Count <= '0;
        end else if (o_PC_Stall && (o_Stall_Count != '1)) begin
            o_Stall_Count <= o_Stall_Count + COUNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: per-cycle expected controls queued at drive time.
module tb_pipe_hazard_ctrl;

    localparam int unsigned AW = 5;
    localparam int unsigned CW = 6;

    // {PC, IF_DEC_S, IF_DEC_F, DEC_EX_S, DEC_EX_F, EX_MEM_S, MEM_WB_S}
    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_HAZ  = 7'b1100100;
    localparam logic [6:0] C_DMEM = 7'b1101011;
    localparam logic [6:0] C_BR   = 7'b0010000;

    typedef struct packed {
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic          urt;
        logic          hl;
        logic          mr;
        logic [AW-1:0] rd;
        logic          br;
        logic          ms;
        logic          dw;
    } stim_t;

    typedef struct {
        stim_t      s;
        logic [6:0] e;
    } vec_t;

    logic          i_Clk;
    logic          i_Reset_n;
    logic [AW-1:0] i_ID_Rs, i_ID_Rt, i_EX_Rd;
    logic          i_ID_Uses_Rt, i_ID_Reads_HiLo, i_EX_MemRead;
    logic          i_Branch_Taken, i_MulDiv_Start, i_Dmem_Wait;
    logic          o_PC_Stall, o_IF_DEC_Stall, o_IF_DEC_Flush;
    logic          o_DEC_EX_Stall, o_DEC_EX_Flush, o_EX_MEM_Stall, o_MEM_WB_Stall;
    logic          o_MulDiv_Busy;
    logic [CW-1:0] o_Stall_Count;
    logic [6:0]    obs_ctrl;

    logic [6:0]    ctrl_q[$];
    logic          busy_q[$];
    logic [CW-1:0] exp_cnt;
    int            n_checks;
    int            n_errors;

    pipe_hazard_ctrl #(
        .REG_ADDR_WIDTH (AW),
        .MULDIV_CYCLES  (32),
        .COUNT_WIDTH    (CW)
    ) dut (
        .i_Clk           (i_Clk),
        .i_Reset_n       (i_Reset_n),
        .i_ID_Rs         (i_ID_Rs),
        .i_ID_Rt         (i_ID_Rt),
        .i_ID_Uses_Rt    (i_ID_Uses_Rt),
        .i_ID_Reads_HiLo (i_ID_Reads_HiLo),
        .i_EX_MemRead    (i_EX_MemRead),
        .i_EX_Rd         (i_EX_Rd),
        .i_Branch_Taken  (i_Branch_Taken),
        .i_MulDiv_Start  (i_MulDiv_Start),
        .i_Dmem_Wait     (i_Dmem_Wait),
        .o_PC_Stall      (o_PC_Stall),
        .o_IF_DEC_Stall  (o_IF_DEC_Stall),
        .o_IF_DEC_Flush  (o_IF_DEC_Flush),
        .o_DEC_EX_Stall  (o_DEC_EX_Stall),
        .o_DEC_EX_Flush  (o_DEC_EX_Flush),
        .o_EX_MEM_Stall  (o_EX_MEM_Stall),
        .o_MEM_WB_Stall  (o_MEM_WB_Stall),
        .o_MulDiv_Busy   (o_MulDiv_Busy),
        .o_Stall_Count   (o_Stall_Count)
    );

    assign obs_ctrl = {o_PC_Stall, o_IF_DEC_Stall, o_IF_DEC_Flush, o_DEC_EX_Stall,
                       o_DEC_EX_Flush, o_EX_MEM_Stall, o_MEM_WB_Stall};

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    function automatic stim_t mk(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                                 input logic urt, input logic hl, input logic mr,
                                 input logic [AW-1:0] rd, input logic br,
                                 input logic ms, input logic dw);
        stim_t s;
        s.rs = rs; s.rt = rt; s.urt = urt; s.hl = hl; s.mr = mr;
        s.rd = rd; s.br = br; s.ms = ms; s.dw = dw;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        i_ID_Rs         = s.rs;
        i_ID_Rt         = s.rt;
        i_ID_Uses_Rt    = s.urt;
        i_ID_Reads_HiLo = s.hl;
        i_EX_MemRead    = s.mr;
        i_EX_Rd         = s.rd;
        i_Branch_Taken  = s.br;
        i_MulDiv_Start  = s.ms;
        i_Dmem_Wait     = s.dw;
    endtask

    task automatic test_reset();
        i_Reset_n = 1'b0;
        apply('0);
        exp_cnt = '0;
        #3;
        n_checks += 3;
        if (obs_ctrl !== C_NONE) begin
            n_errors++; $display("FAIL reset_ctrl got=%b want=%b", obs_ctrl, C_NONE);
        end
        if (o_MulDiv_Busy !== 1'b0) begin
            n_errors++; $display("FAIL reset_busy got=%b want=0", o_MulDiv_Busy);
        end
        if (o_Stall_Count !== '0) begin
            n_errors++; $display("FAIL reset_count got=%0d want=0", o_Stall_Count);
        end
        repeat (2) @(posedge i_Clk);
        @(negedge i_Clk);
        i_Reset_n = 1'b1;
    endtask

    task automatic test_load_use();
        vec_t tbl[6];
        logic [6:0] e;
        logic       eb;
        tbl[0] = '{mk(5, 0, 0, 0, 1, 5, 0, 0, 0), C_HAZ};
        tbl[1] = '{mk(0, 0, 0, 0, 1, 0, 0, 0, 0), C_NONE};
        tbl[2] = '{mk(3, 7, 1, 0, 1, 7, 0, 0, 0), C_HAZ};
        tbl[3] = '{mk(3, 7, 0, 0, 1, 7, 0, 0, 0), C_NONE};
        tbl[4] = '{mk(5, 5, 1, 0, 0, 5, 0, 0, 0), C_NONE};
        tbl[5] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0), C_NONE};
        foreach (tbl[k]) begin
            @(negedge i_Clk);
            apply(tbl[k].s);
            ctrl_q.push_back(tbl[k].e);
            busy_q.push_back(1'b0);
            #2;
            e  = ctrl_q.pop_front();
            eb = busy_q.pop_front();
            n_checks += 3;
            if (obs_ctrl !== e) begin
                n_errors++; $display("FAIL load_use_ctrl[%0d] got=%b want=%b", k, obs_ctrl, e);
            end
            if (o_MulDiv_Busy !== eb) begin
                n_errors++; $display("FAIL load_use_busy[%0d] got=%b want=%b", k, o_MulDiv_Busy, eb);
            end
            if (o_Stall_Count !== exp_cnt) begin
                n_errors++; $display("FAIL load_use_count[%0d] got=%0d want=%0d", k, o_Stall_Count, exp_cnt);
            end
            if (e[6] && (exp_cnt != '1)) exp_cnt++;
        end
    endtask

    task automatic test_priority();
        vec_t tbl[5];
        logic [6:0] e;
        logic       eb;
        tbl[0] = '{mk(9, 0, 0, 0, 1, 9, 1, 0, 0), C_HAZ};
        tbl[1] = '{mk(9, 0, 0, 0, 0, 9, 1, 0, 0), C_BR};
        tbl[2] = '{mk(9, 0, 0, 0, 1, 9, 1, 0, 1), C_DMEM};
        tbl[3] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 1), C_DMEM};
        tbl[4] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0), C_NONE};
        foreach (tbl[k]) begin
            @(negedge i_Clk);
            apply(tbl[k].s);
            ctrl_q.push_back(tbl[k].e);
            busy_q.push_back(1'b0);
            #2;
            e  = ctrl_q.pop_front();
            eb = busy_q.pop_front();
            n_checks += 3;
            if (obs_ctrl !== e) begin
                n_errors++; $display("FAIL priority_ctrl[%0d] got=%b want=%b", k, obs_ctrl, e);
            end
            if (o_MulDiv_Busy !== eb) begin
                n_errors++; $display("FAIL priority_busy[%0d] got=%b want=%b", k, o_MulDiv_Busy, eb);
            end
            if (o_Stall_Count !== exp_cnt) begin
                n_errors++; $display("FAIL priority_count[%0d] got=%0d want=%0d", k, o_Stall_Count, exp_cnt);
            end
            if (e[6] && (exp_cnt != '1)) exp_cnt++;
        end
    endtask

    // with_dmem adds a memory freeze mid-operation and a spurious second start
    task automatic test_hilo(input logic with_dmem);
        logic [6:0] e;
        logic       eb;
        logic       dw;
        for (int k = 0; k <= 40; k++) begin
            dw = with_dmem && (k >= 5) && (k <= 8);
            @(negedge i_Clk);
            apply(mk(0, 0, 0, (k != 0), 0, 0, 0, (k == 0) || (with_dmem && (k == 10)), dw));
            eb = (k >= 1) && (k <= 31);
            ctrl_q.push_back(dw ? C_DMEM : (eb ? C_HAZ : C_NONE));
            busy_q.push_back(eb);
            #2;
            e  = ctrl_q.pop_front();
            eb = busy_q.pop_front();
            n_checks += 3;
            if (obs_ctrl !== e) begin
                n_errors++; $display("FAIL hilo%0d_ctrl[%0d] got=%b want=%b", with_dmem, k, obs_ctrl, e);
            end
            if (o_MulDiv_Busy !== eb) begin
                n_errors++; $display("FAIL hilo%0d_busy[%0d] got=%b want=%b", with_dmem, k, o_MulDiv_Busy, eb);
            end
            if (o_Stall_Count !== exp_cnt) begin
                n_errors++; $display("FAIL hilo%0d_count[%0d] got=%0d want=%0d", with_dmem, k, o_Stall_Count, exp_cnt);
            end
            if (e[6] && (exp_cnt != '1)) exp_cnt++;
        end
    endtask

    task automatic test_reset_mid_mdu();
        logic [6:0] e;
        logic       eb;
        for (int k = 0; k <= 25; k++) begin
            @(negedge i_Clk);
            if (k <= 22) begin
                apply(mk(0, 0, 0, 0, 0, 0, 0, (k == 0), 0));
                eb = (k >= 1);
            end else begin
                apply(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
                eb = 1'b0;
            end
            ctrl_q.push_back(C_NONE);
            busy_q.push_back(eb);
            #2;
            e  = ctrl_q.pop_front();
            eb = busy_q.pop_front();
            n_checks += 3;
            if (obs_ctrl !== e) begin
                n_errors++; $display("FAIL rst_mdu_ctrl[%0d] got=%b want=%b", k, obs_ctrl, e);
            end
            if (o_MulDiv_Busy !== eb) begin
                n_errors++; $display("FAIL rst_mdu_busy[%0d] got=%b want=%b", k, o_MulDiv_Busy, eb);
            end
            if (o_Stall_Count !== exp_cnt) begin
                n_errors++; $display("FAIL rst_mdu_count[%0d] got=%0d want=%0d", k, o_Stall_Count, exp_cnt);
            end
            if (k == 22) begin
                // Down-counter is at 10 here; reset lands between clock edges
                #1 i_Reset_n = 1'b0;
                exp_cnt = '0;
                #1;
                n_checks += 2;
                if (o_MulDiv_Busy !== 1'b0) begin
                    n_errors++; $display("FAIL rst_async_busy got=%b want=0", o_MulDiv_Busy);
                end
                if (o_Stall_Count !== '0) begin
                    n_errors++; $display("FAIL rst_async_count got=%0d want=0", o_Stall_Count);
                end
                @(posedge i_Clk);
                @(negedge i_Clk);
                i_Reset_n = 1'b1;
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_load_use();
        test_priority();
        test_hilo(1'b0);
        test_hilo(1'b1);
        test_reset_mid_mdu();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
